// File: rtl/tc_decoder_arbiter8_if.sv
// Bus bundle for tc_decoder_arbiter8.
//   en   : arbitration enable (requester side -> arbiter)
//   req  : per-requester request, bit i = requester i
//   sel  : current / last owner index, feeds decoder sel2..sel0
//   dis  : decoder disable, 1 when no grant is active
//   gnt  : one-hot grant, equals decoder output for sel when dis=0
//   busy : 1 while a grant is held
interface tc_decoder_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [2:0] sel;
  logic       dis;
  logic [7:0] gnt;
  logic       busy;

  modport master (output en, req, input sel, dis, gnt, busy);
  modport slave  (input en, req, output sel, dis, gnt, busy);
endinterface

// File: rtl/tc_decoder_arbiter8.sv
// Round-robin arbiter sharing one 8-way decoded resource among eight
// requesters. The registered winner drives the select/disable inputs of a
// downstream 3-to-8 decoder and a matching one-hot grant vector. A grant is
// held until the owner drops its request or HOLD_MAX cycles elapse
// (HOLD_MAX=0 means unlimited); one dead cycle always separates grants.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of tc_decoder_arbiter8_if (en, req in; sel, dis, gnt, busy out)
module tc_decoder_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  tc_decoder_arbiter8_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit          HOLD_LIMITED = (HOLD_MAX != 0);
  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_MAX - 1);

  state_t      state;
  logic [2:0]  ptr;
  logic [15:0] cnt;
  logic [2:0]  sel_r;
  logic        dis_r;
  logic [7:0]  gnt_r;
  logic        busy_r;

  logic [2:0]  winner;
  logic        any_req;
  logic        release_now;

  // First set request bit scanning upward from p, wrapping 7 -> 0.
  // Walking offsets from high to low lets the smallest offset win.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] res;
    logic [2:0] idx;
    res = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign winner  = rr_pick(bus.req, ptr);
  assign any_req = |bus.req;

  // Owner dropped its request, or the hold limit is reached. Both at once
  // still produce a single release.
  assign release_now = !bus.req[sel_r] || (HOLD_LIMITED && (cnt == HOLD_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= 3'd0;
      cnt    <= 16'd0;
      sel_r  <= 3'd0;
      dis_r  <= 1'b1;
      gnt_r  <= 8'h00;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (bus.en && any_req) begin
            state  <= GRANT;
            cnt    <= 16'd0;
            sel_r  <= winner;
            dis_r  <= 1'b0;
            gnt_r  <= 8'h01 << winner;
            busy_r <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        GRANT: begin
          // en is deliberately ignored here: a held grant is never revoked by it.
          if (release_now) begin
            state  <= GAP;
            ptr    <= sel_r + 3'd1;
            dis_r  <= 1'b1;
            gnt_r  <= 8'h00;
            busy_r <= 1'b0;
          end else begin
            cnt    <= cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          dis_r  <= 1'b1;
          gnt_r  <= 8'h00;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel  = sel_r;
  assign bus.dis  = dis_r;
  assign bus.gnt  = gnt_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_tc_decoder_arbiter8.sv
module tb_tc_decoder_arbiter8;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tc_decoder_arbiter8_if bus ();

  tc_decoder_arbiter8 #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, how long it has been shown,
  // where the round-robin scan starts, and the last owner index.
  int m_owner;   // -1 when nobody holds the grant
  int m_held;    // cycles the current owner has already seen gnt
  int m_ptr;
  int m_sel;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_sel   = 0;
  endtask

  task automatic model_edge(input logic en, input logic [7:0] req);
    if (m_owner >= 0) begin
      if (!req[m_owner] || (HOLD != 0 && m_held == HOLD)) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else if (en && req != 8'h00) begin
      for (int k = 7; k >= 0; k--)
        if (req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
      m_sel  = m_owner;
      m_held = 1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk({tag, ".sel"},  16'(bus.sel),  16'(m_sel));
    chk({tag, ".dis"},  16'(bus.dis),  16'(m_owner < 0));
    chk({tag, ".gnt"},  16'(bus.gnt),  16'(eg));
    chk({tag, ".busy"}, 16'(bus.busy), 16'(m_owner >= 0));
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs compared 1ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge(bus.en, bus.req);
    #1;
    chk_model(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.sel",  16'(bus.sel),  16'h0);
    chk("rst.dis",  16'(bus.dis),  16'h1);
    chk("rst.gnt",  16'(bus.gnt),  16'h0);
    chk("rst.busy", 16'(bus.busy), 16'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [2:0] sel;
    logic       dis;
    logic [7:0] gnt;
  } vec_t;

  vec_t tbl[18];
  logic [7:0] to_exp[11];
  logic [7:0] r;

  initial begin
    // Directed sequence from reset (HOLD=4): single request, wrap past ptr=7, enable gating.
    tbl[0]  = '{1'b1, 8'h08, 3'd3, 1'b0, 8'h08};
    tbl[1]  = '{1'b1, 8'h08, 3'd3, 1'b0, 8'h08};
    tbl[2]  = '{1'b1, 8'h00, 3'd3, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 8'h00, 3'd3, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 8'h40, 3'd6, 1'b0, 8'h40};
    tbl[5]  = '{1'b1, 8'h41, 3'd6, 1'b0, 8'h40};
    tbl[6]  = '{1'b1, 8'h01, 3'd6, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 8'h41, 3'd0, 1'b0, 8'h01};
    tbl[8]  = '{1'b1, 8'h40, 3'd0, 1'b1, 8'h00};
    tbl[9]  = '{1'b1, 8'h40, 3'd6, 1'b0, 8'h40};
    tbl[10] = '{1'b1, 8'h00, 3'd6, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 8'h10, 3'd6, 1'b1, 8'h00};
    tbl[12] = '{1'b0, 8'h10, 3'd6, 1'b1, 8'h00};
    tbl[13] = '{1'b1, 8'h10, 3'd4, 1'b0, 8'h10};
    tbl[14] = '{1'b0, 8'h10, 3'd4, 1'b0, 8'h10};
    tbl[15] = '{1'b0, 8'h10, 3'd4, 1'b0, 8'h10};
    tbl[16] = '{1'b0, 8'h00, 3'd4, 1'b1, 8'h00};
    tbl[17] = '{1'b0, 8'h10, 3'd4, 1'b1, 8'h00};

    to_exp = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00,
               8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01};

    bus.en  = 1'b0;
    bus.req = 8'h00;
    model_reset();
    apply_reset();

    for (int i = 0; i < 18; i++) begin
      bus.en  = tbl[i].en;
      bus.req = tbl[i].req;
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.sel", i),  16'(bus.sel),  16'(tbl[i].sel));
      chk($sformatf("tbl%0d.dis", i),  16'(bus.dis),  16'(tbl[i].dis));
      chk($sformatf("tbl%0d.gnt", i),  16'(bus.gnt),  16'(tbl[i].gnt));
      chk($sformatf("tbl%0d.busy", i), 16'(bus.busy), 16'(!tbl[i].dis));
    end

    // Fairness: all requesting, each owner holds 2 cycles then drops for one.
    apply_reset();
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step("fair.grant");
      chk($sformatf("fair%0d.gnt", g), 16'(bus.gnt), 16'(8'h01 << (g % 8)));
      step("fair.hold");
      chk($sformatf("fair%0d.hold", g), 16'(bus.gnt), 16'(8'h01 << (g % 8)));
      bus.req = 8'hFF & ~(8'h01 << (g % 8));
      step("fair.gap");
      chk($sformatf("fair%0d.gapdis", g), 16'(bus.dis), 16'h1);
      bus.req = 8'hFF;
    end

    // Timeout: two constant requesters alternate every HOLD cycles.
    apply_reset();
    bus.en  = 1'b1;
    bus.req = 8'h03;
    for (int i = 0; i < 11; i++) begin
      step("tmo");
      chk($sformatf("tmo%0d.gnt", i), 16'(bus.gnt), 16'(to_exp[i]));
    end

    // Asynchronous reset in the middle of a grant, checked before any edge.
    apply_reset();
    bus.req = 8'h04;
    step("arst.pre");
    chk("arst.pre.gnt", 16'(bus.gnt), 16'h04);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.sel",  16'(bus.sel),  16'h0);
    chk("arst.dis",  16'(bus.dis),  16'h1);
    chk("arst.gnt",  16'(bus.gnt),  16'h0);
    chk("arst.busy", 16'(bus.busy), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.req = 8'hFF;
    step("arst.restart");
    chk("arst.restart.gnt", 16'(bus.gnt), 16'h01);

    // Randomized traffic against the model; requests often persist so
    // timeouts and simultaneous release/timeout occur.
    bus.req = 8'h00;
    step("rnd.settle");
    r = 8'h00;
    for (int i = 0; i < 600; i++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) r = 8'($urandom) & 8'($urandom);
      bus.req = r;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
